// File: rtl/key_note_scheduler.sv
// key_note_scheduler
//   Monophonic keypad scheduler for a single shared tone generator. Raw key
//   pins are synchronized and debounced, then arbitrated with last-pressed
//   priority. The generator is driven with a note index and a gate. Every
//   note change inserts a one-cycle gap with the gate low (RETRIG).
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   en       in   synchronous enable; low forces IDLE and clears the debouncer
//   keys_i   in   raw keypad pins, active-high, asynchronous to clk
//   note_o   out  current note index, 0..NKEYS-1 (held while idle)
//   gate_o   out  high while a note is sounding
//   change_o out  one-cycle pulse in the first cycle note_o shows a new note
module key_note_scheduler #(
   parameter int NKEYS     = 15,
   parameter int DB_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [NKEYS-1:0] keys_i,
   output logic [3:0]       note_o,
   output logic             gate_o,
   output logic             change_o
);

   localparam int CNT_W = $clog2(DB_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RETRIG = 2'd1,
      PLAY   = 2'd2
   } state_t;

   // Lowest-index set bit; callers only use the result when v is non-zero.
   function automatic logic [3:0] lowest_idx(input logic [NKEYS-1:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = NKEYS - 1; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   logic [NKEYS-1:0] sync1_q, sync1_d;
   logic [NKEYS-1:0] sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NKEYS-1:0] samp_q, samp_d;
   logic [NKEYS-1:0] deb_q, deb_d;
   logic [NKEYS-1:0] deb_dly_q, deb_dly_d;
   logic [NKEYS-1:0] pend_q, pend_d;
   state_t           state_q, state_d;
   logic [3:0]       note_q, note_d;
   logic             gate_q, gate_d;
   logic             change_q, change_d;

   logic             tick;
   logic [NKEYS-1:0] agree;
   logic [NKEYS-1:0] press;
   logic [NKEYS-1:0] held;
   logic [NKEYS-1:0] press_all;
   logic             cur_held;

   // Synchronizer, sample counter and debounce
   always_comb begin
      sync1_d   = keys_i;
      sync2_d   = sync1_q;
      tick      = (cnt_q == CNT_W'(DB_CYCLES - 1));
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      samp_d    = samp_q;
      deb_d     = deb_q;
      deb_dly_d = deb_q;
      // A key only follows the pins once two consecutive samples agree.
      agree     = ~(sync2_q ^ samp_q);
      if (tick) begin
         samp_d = sync2_q;
         deb_d  = (deb_q & ~agree) | (sync2_q & agree);
      end
      // The synchronizer keeps running while disabled; everything after it
      // restarts so still-held keys come back as fresh presses.
      if (!en) begin
         cnt_d     = '0;
         samp_d    = '0;
         deb_d     = '0;
         deb_dly_d = '0;
      end
   end

   assign press    = deb_q & ~deb_dly_q;
   assign held     = deb_q;
   assign cur_held = |(held & (NKEYS'(1) << note_q));

   // Arbitration and note sequencer
   always_comb begin
      state_d   = state_q;
      note_d    = note_q;
      pend_d    = '0;
      // Presses landing during RETRIG are parked in pend_q so PLAY still
      // sees them on the following cycle.
      press_all = press | pend_q;
      case (state_q)
         IDLE: begin
            if (|press_all) begin
               state_d = RETRIG;
               note_d  = lowest_idx(press_all);
            end
         end
         RETRIG: begin
            state_d = PLAY;
            pend_d  = (pend_q | press) & held;
         end
         PLAY: begin
            if (|press_all) begin
               // Includes a re-press of the current key: retrigger same note.
               state_d = RETRIG;
               note_d  = lowest_idx(press_all);
            end else if (!cur_held) begin
               if (|held) begin
                  state_d = RETRIG;
                  note_d  = lowest_idx(held);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (!en) begin
         state_d = IDLE;
         note_d  = note_q;
         pend_d  = '0;
      end
      gate_d   = (state_d == PLAY);
      change_d = (state_d == RETRIG);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         cnt_q     <= '0;
         samp_q    <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         pend_q    <= '0;
         state_q   <= IDLE;
         note_q    <= 4'd0;
         gate_q    <= 1'b0;
         change_q  <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         cnt_q     <= cnt_d;
         samp_q    <= samp_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_dly_d;
         pend_q    <= pend_d;
         state_q   <= state_d;
         note_q    <= note_d;
         gate_q    <= gate_d;
         change_q  <= change_d;
      end
   end

   assign note_o   = note_q;
   assign gate_o   = gate_q;
   assign change_o = change_q;

endmodule

// File: tb/tb_key_note_scheduler.sv
module tb_key_note_scheduler;

   localparam int NKEYS = 15;
   localparam int DB    = 4;
   localparam int WAITC = 40;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [NKEYS-1:0] keys;
   logic [3:0]       note;
   logic             gate;
   logic             change;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_q[$];
   logic [3:0] exp_note;

   always #5 clk = ~clk;

   key_note_scheduler #(
      .NKEYS    (NKEYS),
      .DB_CYCLES(DB)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .keys_i  (keys),
      .note_o  (note),
      .gate_o  (gate),
      .change_o(change)
   );

   // Scoreboard: every change_o pulse must match the next expected note and
   // must coincide with the gate being low (retrigger gap).
   always @(negedge clk) begin
      if (!rst && change === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: note_o=%0d, no change expected", note);
         end else begin
            exp_note = exp_q.pop_front();
            if (note !== exp_note) begin
               errors++;
               $display("FAIL change_note: note_o=%0d expected %0d", note, exp_note);
            end
         end
         checks++;
         if (gate !== 1'b0) begin
            errors++;
            $display("FAIL retrig_gap: gate_o=%b during change_o, expected 0", gate);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_gate(input logic val, input int max_cyc, output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < max_cyc) begin
         @(negedge clk);
         n++;
         if (gate === val) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      en   = 1'b1;
      keys = '0;
      step(3);
      checks++;
      if (note !== 4'd0) begin
         errors++; $display("FAIL reset_note: note_o=%0d expected 0", note);
      end
      checks++;
      if (gate !== 1'b0) begin
         errors++; $display("FAIL reset_gate: gate_o=%b expected 0", gate);
      end
      checks++;
      if (change !== 1'b0) begin
         errors++; $display("FAIL reset_change: change_o=%b expected 0", change);
      end
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_single();
      bit ok;
      step(8);
      exp_q.push_back(4'd5);
      keys[5] = 1'b1;
      wait_gate(1'b1, WAITC, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL single_gate_on: gate_o=%b expected 1 within %0d cycles", gate, WAITC);
      end
      checks++;
      if (note !== 4'd5) begin
         errors++; $display("FAIL single_note: note_o=%0d expected 5", note);
      end
      keys[5] = 1'b0;
      wait_gate(1'b0, 2 * DB + 6, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL single_gate_off: gate_o=%b expected 0 within %0d cycles", gate, 2 * DB + 6);
      end
      step(15);
      checks++;
      if (note !== 4'd5 || gate !== 1'b0) begin
         errors++; $display("FAIL single_idle_hold: note_o=%0d gate_o=%b expected 5 and 0", note, gate);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL single_pending: %0d changes outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_bounce();
      bit ok;
      // Half-period equal to the sample interval: consecutive debounce
      // samples always disagree, so nothing may get through.
      for (int i = 0; i < 10; i++) begin
         keys[3] = ~keys[3];
         step(DB);
      end
      checks++;
      if (gate !== 1'b0) begin
         errors++; $display("FAIL bounce_gate: gate_o=%b expected 0 while bouncing", gate);
      end
      exp_q.push_back(4'd3);
      keys[3] = 1'b1;
      wait_gate(1'b1, WAITC, ok);
      checks++;
      if (!ok || note !== 4'd3) begin
         errors++; $display("FAIL bounce_settle: gate_o=%b note_o=%0d expected 1 and 3", gate, note);
      end
      step(20);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL bounce_pending: %0d changes outstanding expected 0", exp_q.size());
      end
      keys[3] = 1'b0;
      wait_gate(1'b0, WAITC, ok);
      step(15);
   endtask

   task automatic test_priority();
      bit ok;
      exp_q.push_back(4'd2);
      keys[2] = 1'b1;
      wait_gate(1'b1, WAITC, ok);
      checks++;
      if (!ok || note !== 4'd2) begin
         errors++; $display("FAIL prio_first: gate_o=%b note_o=%0d expected 1 and 2", gate, note);
      end
      step(3);
      exp_q.push_back(4'd9);
      keys[9] = 1'b1;
      wait_gate(1'b0, WAITC, ok);
      step(1);
      checks++;
      if (!ok || gate !== 1'b1 || note !== 4'd9) begin
         errors++; $display("FAIL prio_newer: gate_o=%b note_o=%0d expected 1-cycle gap then 1 and 9", gate, note);
      end
      step(3);
      exp_q.push_back(4'd2);
      keys[9] = 1'b0;
      wait_gate(1'b0, WAITC, ok);
      step(1);
      checks++;
      if (!ok || gate !== 1'b1 || note !== 4'd2) begin
         errors++; $display("FAIL prio_fallback: gate_o=%b note_o=%0d expected 1-cycle gap then 1 and 2", gate, note);
      end
      keys[2] = 1'b0;
      wait_gate(1'b0, WAITC, ok);
      step(15);
      checks++;
      if (!ok || gate !== 1'b0 || note !== 4'd2) begin
         errors++; $display("FAIL prio_idle: gate_o=%b note_o=%0d expected 0 and 2", gate, note);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL prio_pending: %0d changes outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      exp_q.push_back(4'd4);
      keys[7] = 1'b1;
      keys[4] = 1'b1;
      wait_gate(1'b1, WAITC, ok);
      step(3);
      checks++;
      if (!ok || note !== 4'd4) begin
         errors++; $display("FAIL simul_low_wins: gate_o=%b note_o=%0d expected 1 and 4", gate, note);
      end
      exp_q.push_back(4'd7);
      keys[4] = 1'b0;
      wait_gate(1'b0, WAITC, ok);
      step(1);
      checks++;
      if (!ok || gate !== 1'b1 || note !== 4'd7) begin
         errors++; $display("FAIL simul_fallback: gate_o=%b note_o=%0d expected 1 and 7", gate, note);
      end
      keys[7] = 1'b0;
      wait_gate(1'b0, WAITC, ok);
      step(15);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL simul_pending: %0d changes outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_enable();
      bit ok;
      exp_q.push_back(4'd6);
      keys[6] = 1'b1;
      wait_gate(1'b1, WAITC, ok);
      step(2);
      checks++;
      if (!ok || note !== 4'd6) begin
         errors++; $display("FAIL en_play: gate_o=%b note_o=%0d expected 1 and 6", gate, note);
      end
      en = 1'b0;
      step(1);
      checks++;
      if (gate !== 1'b0) begin
         errors++; $display("FAIL en_gate_drop: gate_o=%b expected 0 one cycle after en=0", gate);
      end
      step(6);
      checks++;
      if (gate !== 1'b0 || note !== 4'd6) begin
         errors++; $display("FAIL en_hold: gate_o=%b note_o=%0d expected 0 and 6", gate, note);
      end
      exp_q.push_back(4'd6);
      en = 1'b1;
      wait_gate(1'b1, WAITC, ok);
      step(2);
      checks++;
      if (!ok || note !== 4'd6) begin
         errors++; $display("FAIL en_redetect: gate_o=%b note_o=%0d expected 1 and 6", gate, note);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL en_pending: %0d changes outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid_note();
      // Entered with note 6 sounding from test_enable.
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (gate !== 1'b0 || note !== 4'd0 || change !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: gate_o=%b note_o=%0d change_o=%b expected 0 0 0", gate, note, change);
      end
      keys = '0;
      step(3);
      rst = 1'b0;
      step(20);
      checks++;
      if (gate !== 1'b0 || note !== 4'd0) begin
         errors++; $display("FAIL reset_after: gate_o=%b note_o=%0d expected 0 and 0", gate, note);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_bounce();
      test_priority();
      test_simultaneous();
      test_enable();
      test_reset_mid_note();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
